// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the saturating per-requester grant counters GCNT0/GCNT1.
module alu_arbiter #(
   parameter int WORDSIZE = 4,
   parameter int CYCLES   = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                REQ0,
   input  logic                REQ1,
   input  logic [WORDSIZE-1:0] A0,
   input  logic [WORDSIZE-1:0] B0,
   input  logic [WORDSIZE-1:0] A1,
   input  logic [WORDSIZE-1:0] B1,
   input  logic [3:0]          CTL0,
   input  logic [3:0]          CTL1,
   output logic                GNT0,
   output logic                GNT1,
   output logic                DONE0,
   output logic                DONE1,
`ifdef ALU_ARB_STATS_EN
   output logic [7:0]          GCNT0,
   output logic [7:0]          GCNT1,
`endif
   output logic [WORDSIZE-1:0] R,
   output logic                Z,
   output logic [WORDSIZE-1:0] ALU_A,
   output logic [WORDSIZE-1:0] ALU_B,
   output logic [3:0]          ALU_CTL,
   input  logic [WORDSIZE-1:0] ALU_R,
   input  logic                ALU_Z
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
   localparam logic [1:0] LAST = 2'(CYCLES - 1);
   state_t              state_q, state_d;
   logic                owner_q, prio_q, z_q, sel, start, last;
   logic [1:0]          cnt_q;
   logic [3:0]          ctl_q;
   logic [WORDSIZE-1:0] a_q, b_q, r_q;
   // a lone requester wins regardless of the pointer; the pointer only breaks ties
   assign sel   = (REQ0 && REQ1) ? prio_q : REQ1;
   assign start = (state_q == S_IDLE) && (REQ0 || REQ1);
   assign last  = cnt_q == LAST;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == S_IDLE) ? (start ? S_EXEC : S_IDLE) :
                (state_q == S_EXEC) ? (last ? S_DONE : S_EXEC) : S_IDLE;
   end
   always_comb begin
      GNT0  = (state_q == S_EXEC) && (cnt_q == 2'd0) && !owner_q;
      GNT1  = (state_q == S_EXEC) && (cnt_q == 2'd0) && owner_q;
      DONE0 = (state_q == S_DONE) && !owner_q;
      DONE1 = (state_q == S_DONE) && owner_q;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ctl_q   <= '0;
         cnt_q   <= '0;
         r_q     <= '0;
         z_q     <= 1'b0;
      end else begin
         if (start) begin
            owner_q <= sel;
            prio_q  <= !sel;
            a_q     <= sel ? A1 : A0;
            b_q     <= sel ? B1 : B0;
            ctl_q   <= sel ? CTL1 : CTL0;
            cnt_q   <= '0;
         end
         if (state_q == S_EXEC) begin
            cnt_q <= cnt_q + 2'd1;
            if (last) begin
               r_q <= ALU_R;
               z_q <= ALU_Z;
            end
         end
      end
   end
   assign ALU_A   = a_q;
   assign ALU_B   = b_q;
   assign ALU_CTL = ctl_q;
   assign R       = r_q;
   assign Z       = z_q;
`ifdef ALU_ARB_STATS_EN
   logic [7:0] gcnt0_q, gcnt1_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
      end else begin
         if (GNT0 && gcnt0_q != 8'hFF) gcnt0_q <= gcnt0_q + 8'd1;
         if (GNT1 && gcnt1_q != 8'hFF) gcnt1_q <= gcnt1_q + 8'd1;
      end
   end
   assign GCNT0 = gcnt0_q;
   assign GCNT1 = gcnt1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, corner sequences and randomized model checks for alu_arbiter.
module tb_alu_arbiter;
   localparam int W = 4;
   localparam int C = 1;
   typedef struct {
      logic       r0, r1;
      logic [3:0] a0, b0, c0, a1, b1, c1;
      logic       w;
      logic [3:0] r;
      logic       z;
   } vec_t;
   logic CLK = 1'b0, RST = 1'b1, REQ0 = 1'b0, REQ1 = 1'b0;
   logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic [3:0] CTL0 = '0, CTL1 = '0;
   logic GNT0, GNT1, DONE0, DONE1, Z, ALU_Z;
   logic [W-1:0] R, ALU_A, ALU_B, ALU_R;
   logic [3:0] ALU_CTL;
`ifdef ALU_ARB_STATS_EN
   logic [7:0] GCNT0, GCNT1;
`endif
   int n_chk = 0, n_fail = 0;
   logic prio = 1'b0;
   logic [W-1:0] last_r = '0;
   vec_t tbl[8];
   alu_arbiter #(.WORDSIZE(W), .CYCLES(C)) dut (
      .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
      .A0(A0), .B0(B0), .A1(A1), .B1(B1), .CTL0(CTL0), .CTL1(CTL1),
      .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
`ifdef ALU_ARB_STATS_EN
      .GCNT0(GCNT0), .GCNT1(GCNT1),
`endif
      .R(R), .Z(Z), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CTL(ALU_CTL),
      .ALU_R(ALU_R), .ALU_Z(ALU_Z));
   always #5 CLK = ~CLK;
   function automatic logic [W-1:0] alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      case (c)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return a ^ b;
         default: return a;
      endcase
   endfunction
   assign ALU_R = alu(ALU_CTL, ALU_A, ALU_B);
   assign ALU_Z = ALU_R == '0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // one full transaction from IDLE; returns #1 after the edge that re-enters IDLE
   task automatic run(input vec_t v);
      REQ0 = v.r0; REQ1 = v.r1;
      A0 = v.a0; B0 = v.b0; CTL0 = v.c0;
      A1 = v.a1; B1 = v.b1; CTL1 = v.c1;
      @(posedge CLK); #1;
      chk("gnt0", 32'(GNT0), 32'(!v.w));
      chk("gnt1", 32'(GNT1), 32'(v.w));
      chk("r_hold", 32'(R), 32'(last_r));
      chk("alu_a", 32'(ALU_A), 32'(v.w ? v.a1 : v.a0));
      REQ0 = 1'b0; REQ1 = 1'b0;
      A0 = 4'd1; A1 = 4'd1;
      B0 = 4'($urandom); B1 = 4'($urandom);
      CTL0 = 4'($urandom); CTL1 = 4'($urandom);
      repeat (C) @(posedge CLK);
      #1;
      chk("done0", 32'(DONE0), 32'(!v.w));
      chk("done1", 32'(DONE1), 32'(v.w));
      chk("gnt_in_done", 32'(GNT0 | GNT1), 32'(0));
      chk("r", 32'(R), 32'(v.r));
      chk("z", 32'(Z), 32'(v.z));
      last_r = v.r;
      @(posedge CLK); #1;
      chk("done_idle", 32'(DONE0 | DONE1), 32'(0));
   endtask
   task automatic mrun(input vec_t v);
      v.w = (v.r0 && v.r1) ? prio : v.r1;
      v.r = alu(v.w ? v.c1 : v.c0, v.w ? v.a1 : v.a0, v.w ? v.b1 : v.b0);
      v.z = v.r == '0;
      prio = !v.w;
      run(v);
   endtask
   task automatic rst_pulse();
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      prio = 1'b0;
      last_r = '0;
   endtask
   initial begin
      vec_t v;
      logic [3:0] ops[5];
      int gq[$];
      int dq[$];
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
      tbl[0] = '{1'b1, 1'b1, 4'd5, 4'd5, 4'd6, 4'd3, 4'd6, 4'd1, 1'b0, 4'd0,  1'b1};
      tbl[1] = '{1'b1, 1'b1, 4'd5, 4'd5, 4'd6, 4'd3, 4'd6, 4'd1, 1'b1, 4'd7,  1'b0};
      tbl[2] = '{1'b1, 1'b0, 4'd7, 4'd5, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 4'd12, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 4'd3, 4'd3, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0,  1'b1};
      tbl[4] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd9, 4'd3, 4'd0, 1'b1, 4'd1,  1'b0};
      tbl[5] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd2, 4'd3, 4'd6, 1'b1, 4'd15, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 4'd9, 4'd9, 4'd7, 4'd4, 4'd8, 4'd1, 1'b0, 4'd0,  1'b1};
      tbl[7] = '{1'b1, 1'b1, 4'd9, 4'd9, 4'd7, 4'd4, 4'd8, 4'd1, 1'b1, 4'd12, 1'b0};
      repeat (2) @(posedge CLK);
      #1;
      chk("in_reset", 32'({GNT0, GNT1, DONE0, DONE1, Z, R, ALU_A, ALU_B, ALU_CTL}), 32'(0));
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("after_reset", 32'({GNT0, GNT1, DONE0, DONE1, Z, R, ALU_A, ALU_B, ALU_CTL}), 32'(0));
      for (int i = 0; i < 8; i++) run(tbl[i]);
      REQ0 = 1'b1; A0 = 4'd3; B0 = 4'd4; CTL0 = 4'd2;
      @(posedge CLK); #1;
      chk("abort_gnt0", 32'(GNT0), 32'(1));
      REQ0 = 1'b0;
      RST = 1'b1;
      #1;
      chk("abort_zero", 32'({GNT0, GNT1, DONE0, DONE1, Z, R, ALU_A, ALU_B, ALU_CTL}), 32'(0));
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK); #1;
         chk("abort_no_done", 32'(DONE0 | DONE1), 32'(0));
      end
      RST = 1'b0;
      prio = 1'b0;
      last_r = '0;
      v = '{1'b1, 1'b1, 4'd6, 4'd2, 4'd6, 4'd1, 4'd1, 4'd2, 1'b0, 4'd0, 1'b0};
      mrun(v);
      for (int i = 0; i < 40; i++) begin
         int rq;
         rq = $urandom_range(1, 3);
         v.r0 = rq[0]; v.r1 = rq[1];
         v.a0 = 4'($urandom); v.b0 = 4'($urandom); v.c0 = ops[$urandom_range(0, 4)];
         v.a1 = 4'($urandom); v.b1 = 4'($urandom); v.c1 = ops[$urandom_range(0, 4)];
         mrun(v);
      end
      rst_pulse();
      REQ0 = 1'b1; REQ1 = 1'b1;
      A0 = 4'd2; B0 = 4'd2; CTL0 = 4'd2; A1 = 4'd5; B1 = 4'd1; CTL1 = 4'd6;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(posedge CLK); #1;
         chk("gnt_excl", 32'(GNT0 & GNT1), 32'(0));
         chk("done_excl", 32'(DONE0 & DONE1), 32'(0));
         if (GNT0 || GNT1) gq.push_back(int'(GNT1));
         if (DONE0 || DONE1) dq.push_back(cyc);
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      chk("rr_grants", 32'(gq.size()), 32'(4));
      chk("rr_dones", 32'(dq.size()), 32'(4));
      if (gq.size() == 4 && dq.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(gq[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) chk("done_spacing", 32'(dq[i] - dq[i-1]), 32'(C + 2));
      end
`ifdef ALU_ARB_STATS_EN
      begin
         int g;
         g = 0;
         rst_pulse();
         REQ0 = 1'b1;
         for (int cyc = 0; cyc < 2000 && g < 300; cyc++) begin
            @(posedge CLK); #1;
            if (GNT0) g++;
         end
         REQ0 = 1'b0;
         chk("stats_grants", 32'(g), 32'(300));
         chk("gcnt0", 32'(GCNT0), 32'(255));
         chk("gcnt1", 32'(GCNT1), 32'(0));
      end
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 4: operand/result width in bits.
REQ-002 Parameter CYCLES, default 1, range 1-4: cycles the ALU inputs are held before the result is sampled.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ0, REQ1  input  1 each  request from requester 0 / 1.
REQ-006 A0, B0, A1, B1  input  WORDSIZE each  operands of requester 0 / 1.
REQ-007 CTL0, CTL1  input  4 each  ALU operation code of requester 0 / 1; the arbiter passes it through without decoding.
REQ-008 GNT0, GNT1  output  1 each  one-cycle grant pulse; operands were captured.
REQ-009 DONE0, DONE1  output  1 each  one-cycle pulse; R/Z are valid for that requester.
REQ-010 R  output  WORDSIZE  registered result.
REQ-011 Z  output  1  registered zero flag.
REQ-012 ALU_A, ALU_B  output  WORDSIZE each  operands driven to the shared alu.
REQ-013 ALU_CTL  output  4  operation driven to the shared alu.
REQ-014 ALU_R  input  WORDSIZE  result from the alu.
REQ-015 ALU_Z  input  1  zero flag from the alu.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-017 In IDLE with any REQn high at a rising edge, the FSM SHALL capture that requester's A, B and CTL into internal registers, record it as owner, and enter EXEC.
REQ-018 GNTn SHALL be high exactly during the first EXEC cycle, owner only.
REQ-019 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; after reset, requester 0 has priority.
REQ-020 A single requesting side SHALL be granted regardless of the round-robin pointer.
REQ-021 ALU_A, ALU_B and ALU_CTL SHALL be driven from the capture registers only; they SHALL never be driven combinationally from A0/A1/CTLn.
REQ-022 EXEC SHALL last exactly CYCLES cycles; at its final edge, ALU_R/ALU_Z SHALL be registered into R/Z and the FSM SHALL enter DONE.
REQ-023 DONE SHALL last one cycle with DONEn high for the owner, then return to IDLE.
REQ-024 Latency from the REQ-sampling edge to DONE high SHALL be CYCLES+1 cycles.
REQ-025 Throughput SHALL be at most one operation per CYCLES+2 cycles.
REQ-026 R/Z SHALL hold their value until the next DONE.
REQ-027 Requests arriving in EXEC/DONE SHALL be ignored until IDLE; a REQn still high in IDLE SHALL be treated as a new request.
REQ-028 Operand changes after GNT SHALL NOT affect the operation in flight.
REQ-029 GNT0/GNT1 SHALL never be high simultaneously; the same SHALL hold for DONE0/DONE1.

Reset
REQ-030 On RST the arbiter SHALL enter IDLE and clear to 0: GNTn, DONEn, R, Z, capture registers (hence ALU_A/ALU_B/ALU_CTL), EXEC counter, and round-robin pointer (next priority = requester 0).
REQ-031 RST mid-EXEC or mid-DONE SHALL abort the operation with no DONE pulse.
REQ-032 After RST deasserts, the first grant SHALL occur at the first edge with a request.

Configuration
REQ-033 Macro ALU_ARB_STATS_EN defined: outputs GCNT0 and GCNT1 (8 bits each) SHALL exist.
REQ-034 Each GCNTn SHALL increment on each grant to requester n and saturate at 255.
REQ-035 GCNT0/GCNT1 SHALL clear on RST.
REQ-036 Macro ALU_ARB_STATS_EN undefined: the counters and ports SHALL be absent; all other behaviour is identical.

Verification (WORDSIZE=4, CYCLES=1)
REQ-037 Requester 0 request, REQ0 A0=7 B0=5 CTL0=2, ALU model ADD: expect GNT0 one cycle later, DONE0 two cycles after the request edge, R=12, Z=0.
REQ-038 Simultaneous requests from reset, REQ0 CTL0=6 A0=5 B0=5 and REQ1 CTL1=1 A1=3 B1=6: expect requester 0 served first with R=0 Z=1, then requester 1 with R=7 Z=0.
REQ-039 Both REQ held high for 4 operations: expect grant order 0,1,0,1 and DONE spacing of 3 cycles.
REQ-040 Operands changed after GNT (A0 7->1 after GNT0): expect the result computed from the captured value 7.
REQ-041 RST asserted during EXEC: expect no DONE, all outputs 0, and the next grant to requester 0.
REQ-042 With ALU_ARB_STATS_EN, 300 grants to requester 0: expect GCNT0=255, GCNT1=0.
